// File: rtl/uart_ocp_pkg.sv
// -----------------------------------------------------------------------------
// uart_ocp_pkg
// Shared definitions for the UART-side OCP register bank:
//   - MCmd command encodings (IDLE / WR / RD)
//   - SResp response encodings (NULL / DVA / ERR)
//   - register address map 0x00..0x09 and REG_LAST
//   - transaction FSM state encoding
//   - helper that classifies read-only addresses
// -----------------------------------------------------------------------------
package uart_ocp_pkg;

    // MCmd encodings. Any other value is an illegal command.
    localparam logic [2:0] MCMD_IDLE = 3'b000;
    localparam logic [2:0] MCMD_WR   = 3'b001;
    localparam logic [2:0] MCMD_RD   = 3'b010;

    // SResp encodings.
    localparam logic [1:0] SRESP_NULL = 2'b00;
    localparam logic [1:0] SRESP_DVA  = 2'b01;
    localparam logic [1:0] SRESP_ERR  = 2'b11;

    // Register map.
    localparam logic [7:0] ADDR_ID      = 8'h00;
    localparam logic [7:0] ADDR_SCRATCH = 8'h01;
    localparam logic [7:0] ADDR_LED     = 8'h02;
    localparam logic [7:0] ADDR_GPIO    = 8'h03;
    localparam logic [7:0] ADDR_CTRL    = 8'h04;
    localparam logic [7:0] ADDR_CNT0    = 8'h05;
    localparam logic [7:0] ADDR_CNT1    = 8'h06;
    localparam logic [7:0] ADDR_CNT2    = 8'h07;
    localparam logic [7:0] ADDR_CNT3    = 8'h08;
    localparam logic [7:0] ADDR_WRCNT   = 8'h09;
    localparam logic [7:0] REG_LAST     = 8'h09;

    // CTRL register bit positions.
    localparam int CTRL_CNT_EN  = 0;
    localparam int CTRL_CNT_CLR = 1;

    // Transaction FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // True for addresses inside the map that reject writes.
    function automatic logic is_read_only(input logic [7:0] addr);
        return (addr == ADDR_ID) || (addr == ADDR_GPIO) ||
               ((addr >= ADDR_CNT0) && (addr <= ADDR_WRCNT));
    endfunction

endpackage

// File: rtl/uart_ocp_cnt32.sv
// -----------------------------------------------------------------------------
// uart_ocp_cnt32
// 32-bit free-running counter with enable, synchronous clear and a 24-bit
// snapshot shadow of the upper three bytes. Reading byte0 through the register
// bank captures bytes 3..1 so a multi-read of the counter is coherent.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   en          in   count enable (increment every clock while high)
//   clr         in   zero the counter this cycle; wins over en
//   snap        in   capture bytes 3..1 of the current count into the shadow
//   live_byte0  out  live counter bits 7:0
//   shadow      out  captured counter bits 31:8
// -----------------------------------------------------------------------------
module uart_ocp_cnt32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic        snap,
    output logic [7:0]  live_byte0,
    output logic [23:0] shadow
);

    logic [31:0] cnt_q, cnt_d;
    logic [23:0] shadow_q, shadow_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        if (clr) begin
            cnt_d = 32'h0;
        end else if (en) begin
            cnt_d = cnt_q + 32'd1;  // wraps 0xFFFFFFFF -> 0 naturally
        end
        // The shadow takes the value visible during the snapshot cycle, i.e.
        // the same count whose byte0 is being returned.
        if (snap) begin
            shadow_d = cnt_q[31:8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= 32'h0;
            shadow_q <= 24'h0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign live_byte0 = cnt_q[7:0];
    assign shadow     = shadow_q;

endmodule

// File: rtl/uart_ocp_regs.sv
// -----------------------------------------------------------------------------
// uart_ocp_regs
// OCP-style slave register bank behind the UART transaction master. A command
// seen in IDLE is latched, accepted for one cycle (ACC, where the register
// access happens), optionally delayed RESP_WAIT cycles, then answered for one
// cycle in RESP. All outputs are registered.
//
// Ports:
//   clk              in   system clock
//   reset            in   asynchronous active-high reset
//   uart_MCmd        in   3-bit command (IDLE/WR/RD, others illegal)
//   uart_MAddr       in   8-bit register address
//   uart_MData       in   8-bit write data
//   uart_SCmdAccept  out  one-cycle accept pulse
//   uart_SData       out  read data, valid while SResp != NULL
//   uart_SResp       out  response (NULL/DVA/ERR)
//   gpio_in          in   asynchronous board inputs (synchronized internally)
//   led_out          out  LED register contents
// -----------------------------------------------------------------------------
module uart_ocp_regs
    import uart_ocp_pkg::*;
#(
    parameter logic [7:0]  ID_VALUE  = 8'h5E,
    parameter int unsigned RESP_WAIT = 0,
    parameter logic [7:0]  LED_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] uart_MCmd,
    input  logic [7:0] uart_MAddr,
    input  logic [7:0] uart_MData,
    output logic       uart_SCmdAccept,
    output logic [7:0] uart_SData,
    output logic [1:0] uart_SResp,
    input  logic [7:0] gpio_in,
    output logic [7:0] led_out
);

    localparam logic [3:0] RESP_WAIT_W = 4'(RESP_WAIT);

    // ------------------------------------------------------------------
    // Transaction state
    // ------------------------------------------------------------------
    state_e     state_q;
    logic [2:0] cmd_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [3:0] wait_q;
    logic       accept_q;
    logic [1:0] sresp_q;
    logic [7:0] sdata_q;
    logic [1:0] hold_resp_q;   // response computed in ACC, held across WAIT
    logic [7:0] hold_data_q;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [7:0] scratch_q,   scratch_d;
    logic [7:0] led_q,       led_d;
    logic       cnt_en_q,    cnt_en_d;
    logic [7:0] wrcnt_q,     wrcnt_d;
    logic [7:0] gpio_meta_q, gpio_meta_d;
    logic [7:0] gpio_sync_q, gpio_sync_d;

    // Counter interface
    logic [7:0]  cnt_byte0;
    logic [23:0] cnt_shadow;
    logic        cnt_clr;
    logic        cnt_snap;

    // ------------------------------------------------------------------
    // Access decode; only meaningful while the FSM is in ACC
    // ------------------------------------------------------------------
    logic       in_acc;
    logic       addr_ok;
    logic       rd_ok;
    logic       wr_ok;
    logic [7:0] rd_mux;
    logic [1:0] acc_resp;
    logic [7:0] acc_data;

    assign in_acc  = (state_q == ST_ACC);
    assign addr_ok = (addr_q <= REG_LAST);
    assign rd_ok   = in_acc && (cmd_q == MCMD_RD) && addr_ok;
    assign wr_ok   = in_acc && (cmd_q == MCMD_WR) && addr_ok && !is_read_only(addr_q);

    always_comb begin
        rd_mux = 8'h00;
        case (addr_q)
            ADDR_ID:      rd_mux = ID_VALUE;
            ADDR_SCRATCH: rd_mux = scratch_q;
            ADDR_LED:     rd_mux = led_q;
            ADDR_GPIO:    rd_mux = gpio_sync_q;
            ADDR_CTRL:    rd_mux = {7'h00, cnt_en_q};  // CNT_CLR always reads 0
            ADDR_CNT0:    rd_mux = cnt_byte0;
            ADDR_CNT1:    rd_mux = cnt_shadow[7:0];
            ADDR_CNT2:    rd_mux = cnt_shadow[15:8];
            ADDR_CNT3:    rd_mux = cnt_shadow[23:16];
            ADDR_WRCNT:   rd_mux = wrcnt_q;
            default:      rd_mux = 8'h00;
        endcase
    end

    // Out-of-range addresses, writes to RO registers and illegal commands all
    // fall through to ERR with zero data.
    always_comb begin
        acc_resp = SRESP_ERR;
        acc_data = 8'h00;
        if (rd_ok) begin
            acc_resp = SRESP_DVA;
            acc_data = rd_mux;
        end else if (wr_ok) begin
            acc_resp = SRESP_DVA;
        end
    end

    // ------------------------------------------------------------------
    // Register updates; writes land at the end of the ACC cycle
    // ------------------------------------------------------------------
    always_comb begin
        scratch_d   = scratch_q;
        led_d       = led_q;
        cnt_en_d    = cnt_en_q;
        wrcnt_d     = wrcnt_q;
        gpio_meta_d = gpio_in;
        gpio_sync_d = gpio_meta_q;
        if (wr_ok) begin
            wrcnt_d = wrcnt_q + 8'd1;
            case (addr_q)
                ADDR_SCRATCH: scratch_d = wdata_q;
                ADDR_LED:     led_d     = wdata_q;
                ADDR_CTRL:    cnt_en_d  = wdata_q[CTRL_CNT_EN];
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch_q   <= 8'h00;
            led_q       <= LED_RESET;
            cnt_en_q    <= 1'b0;
            wrcnt_q     <= 8'h00;
            gpio_meta_q <= 8'h00;
            gpio_sync_q <= 8'h00;
        end else begin
            scratch_q   <= scratch_d;
            led_q       <= led_d;
            cnt_en_q    <= cnt_en_d;
            wrcnt_q     <= wrcnt_d;
            gpio_meta_q <= gpio_meta_d;
            gpio_sync_q <= gpio_sync_d;
        end
    end

    // CNT_CLR is a strobe: it acts in the write's accept cycle and is never
    // stored, which is why CTRL bit1 reads back as 0.
    assign cnt_clr  = wr_ok && (addr_q == ADDR_CTRL) && wdata_q[CTRL_CNT_CLR];
    assign cnt_snap = rd_ok && (addr_q == ADDR_CNT0);

    uart_ocp_cnt32 u_cnt (
        .clk        (clk),
        .reset      (reset),
        .en         (cnt_en_q),
        .clr        (cnt_clr),
        .snap       (cnt_snap),
        .live_byte0 (cnt_byte0),
        .shadow     (cnt_shadow)
    );

    // ------------------------------------------------------------------
    // Transaction FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= MCMD_IDLE;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            wait_q      <= 4'd0;
            accept_q    <= 1'b0;
            sresp_q     <= SRESP_NULL;
            sdata_q     <= 8'h00;
            hold_resp_q <= SRESP_NULL;
            hold_data_q <= 8'h00;
        end else begin
            // Accept and response are single-cycle pulses unless re-asserted.
            accept_q <= 1'b0;
            sresp_q  <= SRESP_NULL;
            sdata_q  <= 8'h00;
            case (state_q)
                ST_IDLE: begin
                    if (uart_MCmd != MCMD_IDLE) begin
                        cmd_q    <= uart_MCmd;
                        addr_q   <= uart_MAddr;
                        wdata_q  <= uart_MData;
                        accept_q <= 1'b1;
                        state_q  <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    hold_resp_q <= acc_resp;
                    hold_data_q <= acc_data;
                    wait_q      <= RESP_WAIT_W;
                    if (RESP_WAIT_W == 4'd0) begin
                        sresp_q <= acc_resp;
                        sdata_q <= acc_data;
                        state_q <= ST_RESP;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_q <= wait_q - 4'd1;
                    // Leaving on 1 makes the counter hit 0 exactly as RESP starts.
                    if (wait_q == 4'd1) begin
                        sresp_q <= hold_resp_q;
                        sdata_q <= hold_data_q;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_SCmdAccept = accept_q;
    assign uart_SResp      = sresp_q;
    assign uart_SData      = sdata_q;
    assign led_out         = led_q;

endmodule

// File: tb/tb_uart_ocp_regs.sv
// -----------------------------------------------------------------------------
// tb_uart_ocp_regs
// Two instances share clock and reset: index 0 answers immediately, index 1
// inserts three wait cycles and has a non-zero LED reset value. Expected
// results come from a register-level model: the counter is described as a
// base value plus elapsed cycles since the last CTRL write.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_ocp_regs;

    localparam logic [7:0] ID_VAL = 8'h5E;
    localparam logic [7:0] LED_RST [2] = '{8'h00, 8'h81};
    localparam int         WAITS   [2] = '{0, 3};

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] mcmd  [2];
    logic [7:0] maddr [2];
    logic [7:0] mdata [2];
    logic       accept[2];
    logic [7:0] sdata [2];
    logic [1:0] sresp [2];
    logic [7:0] led   [2];
    logic [7:0] gpio_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_ocp_regs dut0 (
        .clk(clk), .reset(reset),
        .uart_MCmd(mcmd[0]), .uart_MAddr(maddr[0]), .uart_MData(mdata[0]),
        .uart_SCmdAccept(accept[0]), .uart_SData(sdata[0]), .uart_SResp(sresp[0]),
        .gpio_in(gpio_in), .led_out(led[0])
    );

    uart_ocp_regs #(.ID_VALUE(8'h5E), .RESP_WAIT(3), .LED_RESET(8'h81)) dut3 (
        .clk(clk), .reset(reset),
        .uart_MCmd(mcmd[1]), .uart_MAddr(maddr[1]), .uart_MData(mdata[1]),
        .uart_SCmdAccept(accept[1]), .uart_SData(sdata[1]), .uart_SResp(sresp[1]),
        .gpio_in(gpio_in), .led_out(led[1])
    );

    // ---------------- reference model ----------------
    logic [7:0]  m_scratch [2];
    logic [7:0]  m_led     [2];
    logic [7:0]  m_wrcnt   [2];
    bit          m_en      [2];
    logic [31:0] m_base    [2];
    int          m_base_cyc[2];
    logic [23:0] m_shadow  [2];
    logic [7:0]  m_gpio;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_scratch[d]  = 8'h00;
            m_led[d]      = LED_RST[d];
            m_wrcnt[d]    = 8'h00;
            m_en[d]       = 1'b0;
            m_base[d]     = 32'h0;
            m_base_cyc[d] = 0;
            m_shadow[d]   = 24'h0;
        end
    endtask

    // Counter value visible during cycle c.
    function automatic logic [31:0] cnt_at(input int d, input int c);
        if (m_en[d]) return m_base[d] + 32'(c - m_base_cyc[d]);
        return m_base[d];
    endfunction

    // Access performed in ACC cycle a; returns the expected response.
    task automatic model_access(input int d, input logic [2:0] cmd, input logic [7:0] addr,
                                input logic [7:0] wd, input int a,
                                output logic [1:0] resp, output logic [7:0] rdat);
        logic [31:0] v;
        bit legal, ro;
        legal = (addr <= 8'h09);
        ro    = (addr == 8'h00) || (addr == 8'h03) || (addr >= 8'h05 && addr <= 8'h09);
        resp  = 2'b11;
        rdat  = 8'h00;
        if (cmd == 3'b010 && legal) begin
            resp = 2'b01;
            case (addr)
                8'h00: rdat = ID_VAL;
                8'h01: rdat = m_scratch[d];
                8'h02: rdat = m_led[d];
                8'h03: rdat = m_gpio;
                8'h04: rdat = {7'h00, m_en[d]};
                8'h05: begin
                    v = cnt_at(d, a);
                    m_shadow[d] = v[31:8];
                    rdat = v[7:0];
                end
                8'h06: rdat = m_shadow[d][7:0];
                8'h07: rdat = m_shadow[d][15:8];
                8'h08: rdat = m_shadow[d][23:16];
                default: rdat = m_wrcnt[d];
            endcase
        end else if (cmd == 3'b001 && legal && !ro) begin
            resp = 2'b01;
            m_wrcnt[d] = m_wrcnt[d] + 8'd1;
            case (addr)
                8'h01: m_scratch[d] = wd;
                8'h02: m_led[d] = wd;
                default: begin
                    m_base[d]     = wd[1] ? 32'h0 : cnt_at(d, a + 1);
                    m_base_cyc[d] = a + 1;
                    m_en[d]       = wd[0];
                end
            endcase
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction on instance d, driven at a negedge while the DUT idles.
    task automatic txn(input int d, input logic [2:0] cmd, input logic [7:0] addr,
                       input logic [7:0] wd, input bit hold, input string tag);
        logic [1:0] e_resp;
        logic [7:0] e_data;
        mcmd[d]  = cmd;
        maddr[d] = addr;
        mdata[d] = wd;
        model_access(d, cmd, addr, wd, cyc + 1, e_resp, e_data);
        @(negedge clk);
        check({tag, " accept"}, {31'h0, accept[d]}, 32'h1);
        check({tag, " early resp"}, {30'h0, sresp[d]}, 32'h0);
        if (!hold) mcmd[d] = 3'b000;
        for (int i = 0; i < WAITS[d]; i++) begin
            @(negedge clk);
            check({tag, " wait resp"}, {30'h0, sresp[d]}, 32'h0);
        end
        @(negedge clk);
        mcmd[d] = 3'b000;
        check({tag, " resp"},  {30'h0, sresp[d]}, {30'h0, e_resp});
        check({tag, " data"},  {24'h0, sdata[d]}, {24'h0, e_data});
        check({tag, " led"},   {24'h0, led[d]},   {24'h0, m_led[d]});
        check({tag, " acc lo"}, {31'h0, accept[d]}, 32'h0);
        @(negedge clk);
        check({tag, " resp 1cyc"}, {30'h0, sresp[d]}, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic set_gpio(input logic [7:0] v);
        gpio_in = v;
        m_gpio  = v;
        idle(3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] c;
        logic [7:0] ad;
        int r;
        reset   = 1'b1;
        gpio_in = 8'h00;
        m_gpio  = 8'h00;
        for (int d = 0; d < 2; d++) begin
            mcmd[d] = 3'b000; maddr[d] = 8'h00; mdata[d] = 8'h00;
        end
        model_reset();
        idle(3);
        for (int d = 0; d < 2; d++) begin
            check("rst accept", {31'h0, accept[d]}, 32'h0);
            check("rst sresp",  {30'h0, sresp[d]},  32'h0);
            check("rst sdata",  {24'h0, sdata[d]},  32'h0);
            check("rst led",    {24'h0, led[d]},    {24'h0, LED_RST[d]});
        end
        reset = 1'b0;
        idle(2);

        // Basic map
        txn(0, 3'b010, 8'h00, 8'h00, 0, "rd id");
        txn(0, 3'b001, 8'h02, 8'hA5, 0, "wr led");
        txn(0, 3'b010, 8'h02, 8'h00, 0, "rd led");
        txn(0, 3'b010, 8'h09, 8'h00, 0, "rd wrcnt");
        txn(0, 3'b001, 8'h01, 8'h3C, 0, "wr scratch");
        txn(0, 3'b010, 8'h01, 8'h00, 0, "rd scratch");
        set_gpio(8'h96);
        txn(0, 3'b010, 8'h03, 8'h00, 0, "rd gpio");

        // Counter and snapshot
        txn(0, 3'b001, 8'h04, 8'h01, 0, "cnt en");
        idle(10);
        txn(0, 3'b010, 8'h05, 8'h00, 0, "cnt b0");
        txn(0, 3'b010, 8'h06, 8'h00, 0, "cnt b1");
        txn(0, 3'b010, 8'h07, 8'h00, 0, "cnt b2");
        txn(0, 3'b010, 8'h08, 8'h00, 0, "cnt b3");
        txn(0, 3'b010, 8'h04, 8'h00, 0, "rd ctrl");
        txn(0, 3'b001, 8'h04, 8'h03, 0, "cnt clr");
        txn(0, 3'b010, 8'h05, 8'h00, 0, "cnt b0 post clr");

        // Errors and boundaries
        txn(0, 3'b010, 8'h20, 8'h00, 0, "rd 0x20");
        txn(0, 3'b010, 8'h0A, 8'h00, 0, "rd 0x0a");
        txn(0, 3'b001, 8'h00, 8'h77, 0, "wr id");
        txn(0, 3'b001, 8'h09, 8'h77, 0, "wr wrcnt");
        txn(0, 3'b001, 8'h0A, 8'h77, 0, "wr 0x0a");
        txn(0, 3'b111, 8'h01, 8'h55, 0, "mcmd 7");
        txn(0, 3'b010, 8'h09, 8'h00, 0, "wrcnt after err");
        txn(0, 3'b010, 8'h01, 8'h00, 0, "scratch after err");

        // Randomized traffic
        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 4)      c = 3'b010;
            else if (r <= 8) c = 3'b001;
            else             c = 3'($urandom_range(3, 7));
            ad = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(10, 255))
                                               : 8'($urandom_range(0, 9));
            if (k % 20 == 7) set_gpio(8'($urandom));
            txn(0, c, ad, 8'($urandom), 0, "rand");
            idle(int'($urandom_range(0, 2)));
        end

        // Wait-state instance: latency and held command
        txn(1, 3'b010, 8'h00, 8'h00, 0, "w3 rd id");
        txn(1, 3'b001, 8'h01, 8'hC3, 1, "w3 held wr");
        txn(1, 3'b010, 8'h01, 8'h00, 0, "w3 rd scratch");
        txn(1, 3'b010, 8'h09, 8'h00, 0, "w3 wrcnt once");
        txn(1, 3'b001, 8'h02, 8'h3C, 0, "w3 wr led");
        txn(1, 3'b010, 8'h0B, 8'h00, 0, "w3 err");

        // Reset while instance 1 sits in WAIT
        mcmd[1] = 3'b010; maddr[1] = 8'h01; mdata[1] = 8'h00;
        @(negedge clk);
        check("mid accept", {31'h0, accept[1]}, 32'h1);
        mcmd[1] = 3'b000;
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            check("mid rst sresp",  {30'h0, sresp[d]},  32'h0);
            check("mid rst accept", {31'h0, accept[d]}, 32'h0);
            check("mid rst led",    {24'h0, led[d]},    {24'h0, LED_RST[d]});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post rst quiet", {30'h0, sresp[1]}, 32'h0);
        end
        txn(1, 3'b010, 8'h01, 8'h00, 0, "post rst scratch");
        txn(1, 3'b010, 8'h02, 8'h00, 0, "post rst led");
        txn(1, 3'b010, 8'h09, 8'h00, 0, "post rst wrcnt");
        txn(0, 3'b010, 8'h00, 8'h00, 0, "post rst id");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
